piece_engine: RTL and testbench

PIECE_ENGINE -- requirements
Module: piece_engine

---
 rtl/piece_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_piece_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_engine.sv
// Falling-piece engine: turns spawn/move/rotate commands into a candidate
// placement, probes the board one cell per cycle, then commits or rejects it.
module piece_engine #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int XW      = 4,
    parameter int YW      = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd,
    input  logic [2:0]        spawn_type,
    input  logic [XW-1:0]     spawn_x,
    output logic              occ_req,
    output logic [XW-1:0]     occ_x,
    output logic [YW-1:0]     occ_y,
    input  logic              occ_hit,
    output logic              active,
    output logic [2:0]        piece_type,
    output logic [1:0]        rotation,
    output logic [4*XW-1:0]   cells_x,
    output logic [4*YW-1:0]   cells_y,
    output logic [5:0]        colour,
    output logic              resp_valid,
    output logic              resp_ok,
    output logic              locked,
    output logic              game_over
);

    // One extra bit so a cell left of column 0 or past the last row reads as out of range
    localparam int unsigned CXW = XW + 1;
    localparam int unsigned CYW = YW + 1;

    typedef enum logic [1:0] {IDLE, CALC, CHECK, DONE} state_t;

    state_t         state;
    logic [2:0]     cmd_r;
    logic [2:0]     stype_r;
    logic [XW-1:0]  sx_r;
    logic [CXW-1:0] ox;
    logic [CYW-1:0] oy;
    logic [2:0]     cand_type;
    logic [1:0]     cand_rot;
    logic [CXW-1:0] cand_ox;
    logic [CYW-1:0] cand_oy;
    logic [CXW-1:0] cand_cx [4];
    logic [CYW-1:0] cand_cy [4];
    logic           inv;
    logic           fail;
    logic           qd;
    logic [1:0]     idx;

    logic [2:0]     n_type;
    logic [1:0]     n_rot;
    logic [CXW-1:0] n_ox;
    logic [CYW-1:0] n_oy;
    logic           n_inv;
    logic [CXW-1:0] n_cx [4];
    logic [CYW-1:0] n_cy [4];
    logic [3:0]     off;
    logic           fail_now;
    logic [1:0]     nxt_idx;
    logic           nxt_ok;
    logic           calc_ok0;

    // Box-relative {x,y} of cell i for a type at a rotation
    function automatic logic [3:0] shape_cell(input logic [2:0] t, input logic [1:0] r,
                                              input logic [1:0] i);
        logic [15:0] tbl;
        logic [1:0]  x, y, tx, n1;
        case (t)
            3'd0:    tbl = 16'hD951;
            3'd1:    tbl = 16'h9510;
            3'd2:    tbl = 16'h9518;
            3'd3:    tbl = 16'h9584;
            3'd4:    tbl = 16'h5184;
            3'd5:    tbl = 16'h9514;
            3'd6:    tbl = 16'h9540;
            default: tbl = 16'h0000;
        endcase
        x  = tbl[4*i+2 +: 2];
        y  = tbl[4*i +: 2];
        n1 = (t == 3'd0) ? 2'd3 : 2'd2;
        for (int k = 0; k < 3; k++) begin
            if (t != 3'd3 && 2'(k) < r) begin
                tx = n1 - y;
                y  = x;
                x  = tx;
            end
        end
        return {x, y};
    endfunction

    function automatic logic [5:0] colour_of(input logic [2:0] t);
        case (t)
            3'd0:    return 6'b001111;
            3'd1:    return 6'b000011;
            3'd2:    return 6'b111000;
            3'd3:    return 6'b111100;
            3'd4:    return 6'b001100;
            3'd5:    return 6'b110011;
            3'd6:    return 6'b110000;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic in_board(input logic [CXW-1:0] x, input logic [CYW-1:0] y);
        return (x < CXW'(BOARD_W)) && (y < CYW'(BOARD_H));
    endfunction

    assign cmd_ready = resetn && (state == IDLE);

    // Candidate placement derived from the latched command and the live piece
    always_comb begin
        n_type = piece_type;
        n_rot  = rotation;
        n_ox   = ox;
        n_oy   = oy;
        n_inv  = 1'b0;
        off    = 4'd0;
        case (cmd_r)
            3'd0: begin
                n_type = stype_r;
                n_rot  = 2'd0;
                n_ox   = {1'b0, sx_r};
                n_oy   = '0;
                n_inv  = (stype_r == 3'd7);
            end
            3'd1:    begin n_ox  = ox - CXW'(1);       n_inv = !active; end
            3'd2:    begin n_ox  = ox + CXW'(1);       n_inv = !active; end
            3'd3:    begin n_oy  = oy + CYW'(1);       n_inv = !active; end
            3'd4:    begin n_rot = rotation + 2'd1;    n_inv = !active; end
            3'd5:    begin n_rot = rotation - 2'd1;    n_inv = !active; end
            default: n_inv = 1'b1;
        endcase
        for (int i = 0; i < 4; i++) begin
            off     = shape_cell(n_type, n_rot, 2'(i));
            n_cx[i] = n_ox + CXW'(off[3:2]);
            n_cy[i] = n_oy + CYW'(off[1:0]);
        end
    end

    // Probe bookkeeping: a hit answers the query issued one cycle earlier
    always_comb begin
        fail_now = fail || (qd && occ_hit);
        nxt_idx  = idx + 2'd1;
        nxt_ok   = in_board(cand_cx[nxt_idx], cand_cy[nxt_idx]);
        calc_ok0 = in_board(n_cx[0], n_cy[0]);
    end

    // Command FSM with registered probe, piece and response outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cmd_r      <= 3'd0;
            stype_r    <= 3'd0;
            sx_r       <= '0;
            ox         <= '0;
            oy         <= '0;
            cand_type  <= 3'd0;
            cand_rot   <= 2'd0;
            cand_ox    <= '0;
            cand_oy    <= '0;
            for (int i = 0; i < 4; i++) begin
                cand_cx[i] <= '0;
                cand_cy[i] <= '0;
            end
            inv        <= 1'b0;
            fail       <= 1'b0;
            qd         <= 1'b0;
            idx        <= 2'd0;
            occ_req    <= 1'b0;
            occ_x      <= '0;
            occ_y      <= '0;
            active     <= 1'b0;
            piece_type <= 3'd0;
            rotation   <= 2'd0;
            cells_x    <= '0;
            cells_y    <= '0;
            colour     <= 6'd0;
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            locked     <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            locked     <= 1'b0;
            game_over  <= 1'b0;
            qd         <= occ_req;
            case (state)
                IDLE: begin
                    occ_req <= 1'b0;
                    if (cmd_valid) begin
                        cmd_r   <= cmd;
                        stype_r <= spawn_type;
                        sx_r    <= spawn_x;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    cand_type <= n_type;
                    cand_rot  <= n_rot;
                    cand_ox   <= n_ox;
                    cand_oy   <= n_oy;
                    for (int i = 0; i < 4; i++) begin
                        cand_cx[i] <= n_cx[i];
                        cand_cy[i] <= n_cy[i];
                    end
                    inv     <= n_inv;
                    idx     <= 2'd0;
                    occ_x   <= n_cx[0][XW-1:0];
                    occ_y   <= n_cy[0][YW-1:0];
                    occ_req <= !n_inv && calc_ok0;
                    fail    <= n_inv || !calc_ok0;
                    state   <= CHECK;
                end
                CHECK: begin
                    if (idx == 2'd3) begin
                        occ_req <= 1'b0;
                        fail    <= fail_now;
                        state   <= DONE;
                    end else begin
                        occ_x   <= cand_cx[nxt_idx][XW-1:0];
                        occ_y   <= cand_cy[nxt_idx][YW-1:0];
                        occ_req <= !fail_now && nxt_ok;
                        fail    <= fail_now || !nxt_ok;
                        idx     <= nxt_idx;
                    end
                end
                DONE: begin
                    resp_valid <= 1'b1;
                    resp_ok    <= !fail_now;
                    if (!fail_now) begin
                        active     <= 1'b1;
                        piece_type <= cand_type;
                        rotation   <= cand_rot;
                        ox         <= cand_ox;
                        oy         <= cand_oy;
                        colour     <= colour_of(cand_type);
                        for (int i = 0; i < 4; i++) begin
                            cells_x[i*XW +: XW] <= cand_cx[i][XW-1:0];
                            cells_y[i*YW +: YW] <= cand_cy[i][YW-1:0];
                        end
                    end else if (!inv && cmd_r == 3'd3) begin
                        locked <= 1'b1;
                        active <= 1'b0;
                    end else if (!inv && cmd_r == 3'd0) begin
                        game_over <= 1'b1;
                        active    <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_engine.sv
// Directed bench for piece_engine with a small board-occupancy model.
module tb_piece_engine;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd;
    logic [2:0]  spawn_type;
    logic [3:0]  spawn_x;
    logic        occ_req;
    logic [3:0]  occ_x;
    logic [4:0]  occ_y;
    logic        occ_hit;
    logic        active;
    logic [2:0]  piece_type;
    logic [1:0]  rotation;
    logic [15:0] cells_x;
    logic [19:0] cells_y;
    logic [5:0]  colour;
    logic        resp_valid;
    logic        resp_ok;
    logic        locked;
    logic        game_over;

    int npass = 0;
    int nchk  = 0;
    int qcnt  = 0;
    logic bmap [16][32];

    piece_engine dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .spawn_type(spawn_type), .spawn_x(spawn_x),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
        .active(active), .piece_type(piece_type), .rotation(rotation),
        .cells_x(cells_x), .cells_y(cells_y), .colour(colour),
        .resp_valid(resp_valid), .resp_ok(resp_ok), .locked(locked), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Board answers each query on the following cycle
    always @(posedge clk) occ_hit <= occ_req && bmap[occ_x][occ_y];

    always @(negedge clk) if (occ_req) qcnt++;

    typedef struct {
        logic [2:0]  c;
        logic [2:0]  t;
        logic [3:0]  x;
        logic        ok;
        logic        act;
        logic [2:0]  ty;
        logic [1:0]  rot;
        logic [15:0] cx;
        logic [19:0] cy;
        logic [5:0]  col;
        int          nq;
    } vec_t;

    function automatic logic [15:0] px(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [19:0] py(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        nchk++;
        if (act_v !== exp_v) $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
        else npass++;
    endtask

    // Issue one command and capture the response exactly six cycles after accept
    task automatic run_cmd(input logic [2:0] c, input logic [2:0] t, input logic [3:0] x,
                           output logic got, output logic ok, output logic lk,
                           output logic go, output int nq);
        int   w;
        logic early;
        w = 0;
        early = 1'b0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        cmd = c; spawn_type = t; spawn_x = x; cmd_valid = 1'b1;
        @(posedge clk);
        qcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (resp_valid) early = 1'b1;
        end
        @(negedge clk);
        got = resp_valid && !early;
        ok  = resp_ok;
        lk  = locked;
        go  = game_over;
        nq  = qcnt;
    endtask

    task automatic chk_piece(input string nm, input logic a, input logic [2:0] ty,
                             input logic [1:0] r, input logic [15:0] cx,
                             input logic [19:0] cy, input logic [5:0] col);
        chk({nm, " active"}, 32'(active), 32'(a));
        chk({nm, " type"},   32'(piece_type), 32'(ty));
        chk({nm, " rot"},    32'(rotation), 32'(r));
        chk({nm, " cells_x"}, 32'(cells_x), 32'(cx));
        chk({nm, " cells_y"}, 32'(cells_y), 32'(cy));
        chk({nm, " colour"}, 32'(colour), 32'(col));
    endtask

    vec_t vecs [13];

    initial begin
        logic got, ok, lk, go, seen;
        int   nq;
        string nm;

        for (int i = 0; i < 16; i++) for (int j = 0; j < 32; j++) bmap[i][j] = 1'b0;
        resetn = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; spawn_type = 3'd0; spawn_x = 4'd0;
        occ_hit = 1'b0;

        vecs[0]  = '{3'd0, 3'd5, 4'd3, 1'b1, 1'b1, 3'd5, 2'd0, px(4,3,4,5), py(0,1,1,1), 6'b110011, 4};
        vecs[1]  = '{3'd2, 3'd0, 4'd0, 1'b1, 1'b1, 3'd5, 2'd0, px(5,4,5,6), py(0,1,1,1), 6'b110011, 4};
        vecs[2]  = '{3'd3, 3'd0, 4'd0, 1'b1, 1'b1, 3'd5, 2'd0, px(5,4,5,6), py(1,2,2,2), 6'b110011, 4};
        vecs[3]  = '{3'd4, 3'd0, 4'd0, 1'b1, 1'b1, 3'd5, 2'd1, px(6,5,5,5), py(2,1,2,3), 6'b110011, 4};
        vecs[4]  = '{3'd6, 3'd0, 4'd0, 1'b0, 1'b1, 3'd5, 2'd1, px(6,5,5,5), py(2,1,2,3), 6'b110011, 0};
        vecs[5]  = '{3'd5, 3'd0, 4'd0, 1'b1, 1'b1, 3'd5, 2'd0, px(5,4,5,6), py(1,2,2,2), 6'b110011, 4};
        vecs[6]  = '{3'd0, 3'd0, 4'd6, 1'b1, 1'b1, 3'd0, 2'd0, px(6,7,8,9), py(1,1,1,1), 6'b001111, 4};
        vecs[7]  = '{3'd2, 3'd0, 4'd0, 1'b0, 1'b1, 3'd0, 2'd0, px(6,7,8,9), py(1,1,1,1), 6'b001111, 3};
        vecs[8]  = '{3'd4, 3'd0, 4'd0, 1'b1, 1'b1, 3'd0, 2'd1, px(8,8,8,8), py(0,1,2,3), 6'b001111, 4};
        vecs[9]  = '{3'd5, 3'd0, 4'd0, 1'b1, 1'b1, 3'd0, 2'd0, px(6,7,8,9), py(1,1,1,1), 6'b001111, 4};
        vecs[10] = '{3'd0, 3'd0, 4'd0, 1'b1, 1'b1, 3'd0, 2'd0, px(0,1,2,3), py(1,1,1,1), 6'b001111, 4};
        vecs[11] = '{3'd1, 3'd0, 4'd0, 1'b0, 1'b1, 3'd0, 2'd0, px(0,1,2,3), py(1,1,1,1), 6'b001111, 0};
        vecs[12] = '{3'd0, 3'd7, 4'd2, 1'b0, 1'b1, 3'd0, 2'd0, px(0,1,2,3), py(1,1,1,1), 6'b001111, 0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst occ_req", 32'(occ_req), 32'd0);
        chk_piece("rst", 1'b0, 3'd0, 2'd0, 16'd0, 20'd0, 6'd0);
        resetn = 1'b1;
        #1 chk("rel cmd_ready", 32'(cmd_ready), 32'd1);

        // Table of single commands on an empty board
        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i].c, vecs[i].t, vecs[i].x, got, ok, lk, go, nq);
            nm = $sformatf("row%0d", i);
            chk({nm, " resp"},    32'(got), 32'd1);
            chk({nm, " ok"},      32'(ok), 32'(vecs[i].ok));
            chk({nm, " queries"}, 32'(nq), 32'(vecs[i].nq));
            chk({nm, " locked"},  32'(lk), 32'd0);
            chk({nm, " gameover"}, 32'(go), 32'd0);
            chk_piece(nm, vecs[i].act, vecs[i].ty, vecs[i].rot, vecs[i].cx, vecs[i].cy, vecs[i].col);
        end

        // J dropped to (4,5), rotated CW then back CCW
        run_cmd(3'd0, 3'd1, 4'd4, got, ok, lk, go, nq);
        chk("J spawn ok", 32'(ok), 32'd1);
        for (int k = 0; k < 5; k++) begin
            run_cmd(3'd3, 3'd0, 4'd0, got, ok, lk, go, nq);
            chk($sformatf("J down%0d ok", k), 32'(ok && got), 32'd1);
        end
        chk_piece("J at 4,5", 1'b1, 3'd1, 2'd0, px(4,4,5,6), py(5,6,6,6), 6'b000011);
        run_cmd(3'd4, 3'd0, 4'd0, got, ok, lk, go, nq);
        chk("J cw ok", 32'(ok), 32'd1);
        chk_piece("J cw", 1'b1, 3'd1, 2'd1, px(6,5,5,5), py(5,5,6,7), 6'b000011);
        run_cmd(3'd5, 3'd0, 4'd0, got, ok, lk, go, nq);
        chk("J ccw ok", 32'(ok), 32'd1);
        chk_piece("J ccw", 1'b1, 3'd1, 2'd0, px(4,4,5,6), py(5,6,6,6), 6'b000011);

        // O lands on an occupied cell below it
        run_cmd(3'd0, 3'd3, 4'd2, got, ok, lk, go, nq);
        chk("O spawn ok", 32'(ok), 32'd1);
        chk_piece("O spawn", 1'b1, 3'd3, 2'd0, px(3,4,3,4), py(0,0,1,1), 6'b111100);
        bmap[3][2] = 1'b1;
        run_cmd(3'd3, 3'd0, 4'd0, got, ok, lk, go, nq);
        chk("O down resp", 32'(got), 32'd1);
        chk("O down ok", 32'(ok), 32'd0);
        chk("O locked", 32'(lk), 32'd1);
        chk("O gameover", 32'(go), 32'd0);
        chk("O active", 32'(active), 32'd0);
        chk_piece("O kept", 1'b0, 3'd3, 2'd0, px(3,4,3,4), py(0,0,1,1), 6'b111100);
        @(negedge clk);
        chk("O locked pulse", 32'(locked), 32'd0);
        chk("O resp pulse", 32'(resp_valid), 32'd0);
        bmap[3][2] = 1'b0;

        // Z spawns onto an occupied cell; a later down is rejected without queries
        bmap[0][0] = 1'b1;
        run_cmd(3'd0, 3'd6, 4'd0, got, ok, lk, go, nq);
        chk("Z resp", 32'(got), 32'd1);
        chk("Z ok", 32'(ok), 32'd0);
        chk("Z gameover", 32'(go), 32'd1);
        chk("Z locked", 32'(lk), 32'd0);
        chk("Z active", 32'(active), 32'd0);
        @(negedge clk);
        chk("Z gameover pulse", 32'(game_over), 32'd0);
        run_cmd(3'd3, 3'd0, 4'd0, got, ok, lk, go, nq);
        chk("dead down resp", 32'(got), 32'd1);
        chk("dead down ok", 32'(ok), 32'd0);
        chk("dead down queries", 32'(nq), 32'd0);
        chk("dead down locked", 32'(lk), 32'd0);
        bmap[0][0] = 1'b0;

        // Reset while the probe sequence is in flight
        @(negedge clk);
        cmd = 3'd0; spawn_type = 3'd5; spawn_x = 4'd3; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid probe occ_req", 32'(occ_req), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort cmd_ready", 32'(cmd_ready), 32'd0);
        chk("abort resp_valid", 32'(resp_valid), 32'd0);
        chk("abort occ_req", 32'(occ_req), 32'd0);
        chk("abort locked", 32'(locked), 32'd0);
        chk("abort gameover", 32'(game_over), 32'd0);
        chk_piece("abort", 1'b0, 3'd0, 2'd0, 16'd0, 20'd0, 6'd0);
        resetn = 1'b1;
        #1 chk("abort rel ready", 32'(cmd_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("abort no resp", 32'(seen), 32'd0);

        run_cmd(3'd0, 3'd5, 4'd3, got, ok, lk, go, nq);
        chk("post rst resp", 32'(got && ok), 32'd1);
        chk_piece("post rst", 1'b1, 3'd5, 2'd0, px(4,3,4,5), py(0,1,1,1), 6'b110011);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
